player_pos_ctl: RTL and testbench

Converts the raw mouse cursor position into a legal, speed-limited mallet position for one player. The block sits directly upstream of the ball controller and drives its `xpos_player_1`/`ypos_player_1` inputs. The second instance, with `SIDE=1`, drives the player-2 mallet. It confines the mallet to its own half of the rink and moves it toward the cursor in bounded steps at a fixed update rate. It also reports the last applied step as a velocity for hit handling.

---
 rtl/player_pos_ctl_if.sv | 21 ++
 rtl/player_pos_ctl.sv | 119 +++++++++++
 tb/tb_player_pos_ctl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/player_pos_ctl_if.sv
// Mouse-in / mallet-out signal bundle for one player position controller.
// slave: the controller; master: the cursor source and mallet consumer.
interface player_pos_ctl_if;
  logic [11:0] xpos_mouse;
  logic [11:0] ypos_mouse;
  logic [11:0] xpos_player;
  logic [11:0] ypos_player;
  logic [4:0]  xvel_player;
  logic [4:0]  yvel_player;
  logic        update_tick;

  modport slave (
    input  xpos_mouse, ypos_mouse,
    output xpos_player, ypos_player, xvel_player, yvel_player, update_tick
  );

  modport master (
    output xpos_mouse, ypos_mouse,
    input  xpos_player, ypos_player, xvel_player, yvel_player, update_tick
  );
endinterface

// File: rtl/player_pos_ctl.sv
// Clamps the cursor to one half of the rink and moves the mallet toward it once per tick.
// Define PLAYER_POS_SPEED_LIMIT_EN for bounded steps; otherwise the target loads directly.
module player_pos_ctl #(
  parameter int unsigned PLAYERS_RADIUS = 20,
  parameter int unsigned SIDE           = 0,
  parameter int unsigned MAX_STEP       = 4,
  parameter int unsigned UPDATE_DIV     = 65000
) (
  input logic             clk_in,
  input logic             rst,
  player_pos_ctl_if.slave pos_io
);

  localparam logic [11:0] XMin   = 12'((SIDE != 0) ? 512 + PLAYERS_RADIUS : 44 + PLAYERS_RADIUS);
  localparam logic [11:0] XMax   = 12'((SIDE != 0) ? 979 - PLAYERS_RADIUS : 511 - PLAYERS_RADIUS);
  localparam logic [11:0] YMin   = 12'(44 + PLAYERS_RADIUS);
  localparam logic [11:0] YMax   = 12'(725 - PLAYERS_RADIUS);
  localparam logic [11:0] XRst   = 12'((SIDE != 0) ? 823 : 200);
  localparam logic [11:0] YRst   = 12'd362;
  localparam logic [16:0] DivLast = 17'(UPDATE_DIV - 1);
  localparam logic signed [12:0] Step = 13'(MAX_STEP);

  typedef struct packed {
    logic [11:0] pos;
    logic [4:0]  vel;
  } axis_t;

  function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lo,
                                        input logic [11:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic axis_t step_axis(input logic [11:0] tgt, input logic [11:0] pos);
    axis_t             r;
    logic signed [12:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, pos});
`ifdef PLAYER_POS_SPEED_LIMIT_EN
    if (d > Step) begin
      r.pos = pos + 12'(MAX_STEP);
      r.vel = 5'(Step);
    end else if (d < -Step) begin
      r.pos = pos - 12'(MAX_STEP);
      r.vel = 5'(-Step);
    end else begin
      r.pos = tgt;
      r.vel = d[4:0];
    end
`else
    r.pos = tgt;
    if (d > 13'sd15)       r.vel = 5'sd15;
    else if (d < -13'sd15) r.vel = -5'sd15;
    else                   r.vel = d[4:0];
`endif
    return r;
  endfunction

  logic [11:0] target_x_q, target_x_d, target_y_q, target_y_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [4:0]  xvel_q, xvel_d, yvel_q, yvel_d;
  logic [16:0] div_cnt_q, div_cnt_d;
  logic        tick_q, tick_d;
  axis_t       step_x, step_y;

  always_comb begin
    target_x_d = clamp(pos_io.xpos_mouse, XMin, XMax);
    target_y_d = clamp(pos_io.ypos_mouse, YMin, YMax);

    div_cnt_d = div_cnt_q + 17'd1;
    tick_d    = 1'b0;
    if (div_cnt_q == DivLast) begin
      div_cnt_d = '0;
      tick_d    = 1'b1;
    end

    step_x = step_axis(target_x_q, xpos_q);
    step_y = step_axis(target_y_q, ypos_q);
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    xvel_d = xvel_q;
    yvel_d = yvel_q;
    if (tick_q) begin
      xpos_d = step_x.pos;
      ypos_d = step_y.pos;
      xvel_d = step_x.vel;
      yvel_d = step_y.vel;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      target_x_q <= XRst;
      target_y_q <= YRst;
      xpos_q     <= XRst;
      ypos_q     <= YRst;
      xvel_q     <= '0;
      yvel_q     <= '0;
      div_cnt_q  <= '0;
      tick_q     <= 1'b0;
    end else begin
      target_x_q <= target_x_d;
      target_y_q <= target_y_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      xvel_q     <= xvel_d;
      yvel_q     <= yvel_d;
      div_cnt_q  <= div_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign pos_io.xpos_player = xpos_q;
  assign pos_io.ypos_player = ypos_q;
  assign pos_io.xvel_player = xvel_q;
  assign pos_io.yvel_player = yvel_q;
  assign pos_io.update_tick = tick_q;

endmodule

// File: tb/tb_player_pos_ctl.sv
// Directed bench for player_pos_ctl: a left-half and a right-half instance on a short divider.
// Expected values follow PLAYER_POS_SPEED_LIMIT_EN as defined for the build.
module tb_player_pos_ctl;
  localparam int Div = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  player_pos_ctl_if if0 ();
  player_pos_ctl_if if1 ();

  player_pos_ctl #(.PLAYERS_RADIUS(20), .SIDE(0), .MAX_STEP(4), .UPDATE_DIV(Div)) dut0 (
    .clk_in (clk),
    .rst    (rst),
    .pos_io (if0)
  );

  player_pos_ctl #(.PLAYERS_RADIUS(20), .SIDE(1), .MAX_STEP(4), .UPDATE_DIV(Div)) dut1 (
    .clk_in (clk),
    .rst    (rst),
    .pos_io (if1)
  );

  typedef struct {
    int do_rst;
    int mx, my;
    int ex, ey, evx, evy;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   box_viol = 0;

  function automatic vec_t mk(int r, int mx, int my, int ex, int ey, int evx, int evy);
    vec_t v;
    v.do_rst = r; v.mx = mx; v.my = my;
    v.ex = ex; v.ey = ey; v.evx = evx; v.evy = evy;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pos(input string name, input int ex, input int ey, input int evx,
                           input int evy);
    check({name, "_x"}, int'(if0.xpos_player), ex);
    check({name, "_y"}, int'(if0.ypos_player), ey);
    check({name, "_vx"}, int'($signed(if0.xvel_player)), evx);
    check({name, "_vy"}, int'($signed(if0.yvel_player)), evy);
  endtask

  // Counts rising edges until update_tick is seen just after an edge; -1 on timeout.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 4 * Div; i++) begin
      @(posedge clk);
      #1;
      if (if0.update_tick) begin
        n = i;
        return;
      end
    end
  endtask

  // Leaves rst low just after an edge, so the next edge is the first with rst low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_pos("rst", 200, 362, 0, 0);
    check("rst_tick", int'(if0.update_tick), 0);
    check("rst_x1", int'(if1.xpos_player), 823);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (if0.xpos_player < 64 || if0.xpos_player > 491 || if0.ypos_player < 64 ||
        if0.ypos_player > 705 || if1.xpos_player < 532 || if1.xpos_player > 959 ||
        if1.ypos_player < 64 || if1.ypos_player > 705)
      box_viol++;
  end

  initial begin
    int n;
    if0.xpos_mouse = 12'd200;
    if0.ypos_mouse = 12'd362;
    if1.xpos_mouse = 12'd100;
    if1.ypos_mouse = 12'd800;

`ifdef PLAYER_POS_SPEED_LIMIT_EN
    tbl.push_back(mk(1, 220, 362, 204, 362, 4, 0));
    tbl.push_back(mk(0, 220, 362, 208, 362, 4, 0));
    tbl.push_back(mk(0, 220, 362, 212, 362, 4, 0));
    tbl.push_back(mk(0, 220, 362, 216, 362, 4, 0));
    tbl.push_back(mk(0, 220, 362, 220, 362, 4, 0));
    tbl.push_back(mk(0, 220, 362, 220, 362, 0, 0));
    tbl.push_back(mk(1, 198, 359, 198, 359, -2, -3));
    tbl.push_back(mk(0, 230, 359, 202, 359, 4, 0));
    tbl.push_back(mk(0, 230, 359, 206, 359, 4, 0));
    tbl.push_back(mk(0, 100, 359, 202, 359, -4, 0));
    tbl.push_back(mk(0, 203, 370, 203, 363, 1, 4));
    tbl.push_back(mk(0, 10, 2000, 199, 367, -4, 4));
`else
    tbl.push_back(mk(1, 220, 362, 220, 362, 15, 0));
    tbl.push_back(mk(0, 220, 362, 220, 362, 0, 0));
    tbl.push_back(mk(1, 198, 359, 198, 359, -2, -3));
    tbl.push_back(mk(1, 400, 500, 400, 500, 15, 15));
    tbl.push_back(mk(0, 390, 505, 390, 505, -10, 5));
    tbl.push_back(mk(0, 10, 2000, 64, 705, -15, 15));
    tbl.push_back(mk(0, 900, 10, 491, 64, 15, -15));
    tbl.push_back(mk(0, 491, 64, 491, 64, 0, 0));
`endif

    foreach (tbl[i]) begin
      if0.xpos_mouse = 12'(tbl[i].mx);
      if0.ypos_mouse = 12'(tbl[i].my);
      if (tbl[i].do_rst != 0) begin
        do_reset();
        wait_tick(n);
        check($sformatf("v%0d_first_tick", i), n, Div);
      end else begin
        wait_tick(n);
        check($sformatf("v%0d_period", i), n, Div - 1);
      end
      @(posedge clk);
      #1;
      check_pos($sformatf("v%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].evx, tbl[i].evy);
    end

    // Both halves converge to the clamped corner nearest the cursor.
    if0.xpos_mouse = 12'd900;
    if0.ypos_mouse = 12'd10;
    do_reset();
    for (int t = 0; t < 120; t++) begin
      wait_tick(n);
      if (n < 0) begin
        check("clamp_tick", n, Div);
        break;
      end
      @(posedge clk);
      #1;
      if (if0.xpos_player == 12'd491 && if0.ypos_player == 12'd64 &&
          if1.xpos_player == 12'd532 && if1.ypos_player == 12'd705)
        break;
    end
    wait_tick(n);
    @(posedge clk);
    #1;
    check_pos("clamp0", 491, 64, 0, 0);
    check("clamp1_x", int'(if1.xpos_player), 532);
    check("clamp1_y", int'(if1.ypos_player), 705);

    // Reset between ticks restores the start point and restarts the divider.
    do_reset();
    repeat (2) begin
      wait_tick(n);
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_pos("midrst", 200, 362, 0, 0);
    check("midrst_tick", int'(if0.update_tick), 0);
    rst = 1'b0;
    wait_tick(n);
    check("midrst_first_tick", n, Div);
    @(posedge clk);
    #1;
`ifdef PLAYER_POS_SPEED_LIMIT_EN
    check_pos("midrst_step", 204, 358, 4, -4);
`else
    check_pos("midrst_step", 491, 64, 15, -15);
`endif

    check("box_violations", box_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
